// File: rtl/multu_arbiter_if.sv
// Handshake and multiplier-side bundle between the two requesters, the
// arbiter and the shared MULTU unit.
interface multu_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [63:0] rsp_z;
    logic        busy;
    logic        mul_reset;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  mul_z,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_z, busy,
        output mul_reset, mul_a, mul_b
    );

    // Requester / multiplier side.
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output mul_z,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_z, busy,
        input  mul_reset, mul_a, mul_b
    );
endinterface

// File: rtl/multu_arbiter.sv
// Round-robin two-port front end for the shared multi-cycle MULTU: grants one
// request, sequences the multiplier for a fixed latency and returns the product.
module multu_arbiter #(
    parameter int MUL_LATENCY = 32
) (
    input  logic           clk,
    input  logic           reset,
    multu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        last_grant_reg, last_grant_next;
    logic        grant_id_reg, grant_id_next;
    logic [31:0] mul_a_reg, mul_a_next;
    logic [31:0] mul_b_reg, mul_b_next;
    logic [63:0] rsp_z_reg, rsp_z_next;

    logic [1:0]  req_valid;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [1:0]  ready_vec;
    logic [1:0]  rsp_vec;
    logic        pick;
    logic        accept;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;

    // On a tie the port not served last wins; otherwise the lone requester.
    assign pick   = (&req_valid) ? ~last_grant_reg : req_valid[1];
    assign accept = (state_reg == IDLE) && (|req_valid) && !reset;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ready_vec[gi] = accept && (pick == (gi == 1));
            assign rsp_vec[gi]   = (state_reg == DONE) && (grant_id_reg == (gi == 1));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        mul_a_next      = mul_a_reg;
        mul_b_next      = mul_b_reg;
        rsp_z_next      = rsp_z_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    mul_a_next      = pick ? req_a[1] : req_a[0];
                    mul_b_next      = pick ? req_b[1] : req_b[0];
                    grant_id_next   = pick;
                    last_grant_next = pick;
                    state_next      = LOAD;
                end
            end
            LOAD: begin
                cnt_next   = 8'(MUL_LATENCY - 1);
                state_next = RUN;
            end
            RUN: begin
                // cnt counts down MUL_LATENCY-1..0, so RUN spans MUL_LATENCY cycles.
                if (cnt_reg == 8'd0) begin
                    rsp_z_next = bus.mul_z;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            last_grant_reg <= 1'b1;
            grant_id_reg   <= 1'b0;
            mul_a_reg      <= 32'd0;
            mul_b_reg      <= 32'd0;
            rsp_z_reg      <= 64'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            mul_a_reg      <= mul_a_next;
            mul_b_reg      <= mul_b_next;
            rsp_z_reg      <= rsp_z_next;
        end
    end

    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];
    assign bus.rsp0_valid = rsp_vec[0];
    assign bus.rsp1_valid = rsp_vec[1];
    assign bus.rsp_z      = rsp_z_reg;
    assign bus.busy       = (state_reg != IDLE);
    // The multiplier only runs while we are in RUN.
    assign bus.mul_reset  = (state_reg != RUN);
    assign bus.mul_a      = mul_a_reg;
    assign bus.mul_b      = mul_b_reg;
endmodule

// File: tb/tb_multu_arbiter.sv
// Directed bench for multu_arbiter: two instances (latency 32 and 1), each
// driving a behavioural MULTU that yields garbage until its latency is met.
module tb_multu_arbiter;
    localparam int L0 = 32;
    localparam int L1 = 1;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multu_arbiter_if bus0();
    multu_arbiter_if bus1();

    multu_arbiter #(.MUL_LATENCY(L0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    multu_arbiter #(.MUL_LATENCY(L1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Behavioural multipliers: product valid once reset has been low for the latency.
    logic [7:0] mcnt0, mcnt1;
    always @(posedge clk) begin
        if (bus0.mul_reset) mcnt0 <= 8'd0;
        else if (mcnt0 != 8'hFF) mcnt0 <= mcnt0 + 8'd1;
        if (bus1.mul_reset) mcnt1 <= 8'd0;
        else if (mcnt1 != 8'hFF) mcnt1 <= mcnt1 + 8'd1;
    end
    assign bus0.mul_z = (!bus0.mul_reset && mcnt0 >= 8'(L0 - 1)) ?
                        {32'd0, bus0.mul_a} * {32'd0, bus0.mul_b} : 64'hDEAD_BEEF_DEAD_BEEF;
    assign bus1.mul_z = (!bus1.mul_reset && mcnt1 >= 8'(L1 - 1)) ?
                        {32'd0, bus1.mul_a} * {32'd0, bus1.mul_b} : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    int          acc_port_q[$];
    int          acc_cyc_q[$];
    int          rsp_port_q[$];
    int          rsp_cyc_q[$];
    logic [63:0] rsp_z_q[$];
    logic        prev_rsp = 1'b0;

    // Transaction monitor for the latency-32 instance.
    always @(negedge clk) begin
        if (bus0.req0_valid || bus0.req1_valid)
            chk("one_ready", 64'(bus0.req0_ready & bus0.req1_ready), 64'd0);
        if (bus0.req0_ready && bus0.req0_valid) begin
            acc_port_q.push_back(0);
            acc_cyc_q.push_back(cyc + 1);
            $display("accept port 0 a=%h b=%h edge %0d", bus0.req0_a, bus0.req0_b, cyc + 1);
        end
        if (bus0.req1_ready && bus0.req1_valid) begin
            acc_port_q.push_back(1);
            acc_cyc_q.push_back(cyc + 1);
            $display("accept port 1 a=%h b=%h edge %0d", bus0.req1_a, bus0.req1_b, cyc + 1);
        end
        if (bus0.rsp0_valid || bus0.rsp1_valid) begin
            chk("rsp_excl", 64'(bus0.rsp0_valid & bus0.rsp1_valid), 64'd0);
            chk("rsp_pulse", 64'(prev_rsp), 64'd0);
            rsp_port_q.push_back(bus0.rsp1_valid ? 1 : 0);
            rsp_cyc_q.push_back(cyc);
            rsp_z_q.push_back(bus0.rsp_z);
            $display("response port %0d z=%h cycle %0d", bus0.rsp1_valid ? 1 : 0, bus0.rsp_z, cyc);
        end
        prev_rsp <= bus0.rsp0_valid | bus0.rsp1_valid;
    end

    task automatic clr_q();
        acc_port_q.delete();
        acc_cyc_q.delete();
        rsp_port_q.delete();
        rsp_cyc_q.delete();
        rsp_z_q.delete();
    endtask

    task automatic wait_accept(input int port);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port == 1 ? bus0.req1_ready : bus0.req0_ready) && n < 200);
        chk("accept_in_time", 64'(n < 200), 64'd1);
        @(posedge clk);
        #1;
        if (port == 1) bus0.req1_valid = 1'b0;
        else           bus0.req0_valid = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input int i, input int port, input logic [63:0] z);
        chk({tag, "_present"}, 64'(rsp_port_q.size() > i), 64'd1);
        if (rsp_port_q.size() > i) begin
            chk({tag, "_port"}, 64'(rsp_port_q[i]), 64'(port));
            chk({tag, "_z"}, rsp_z_q[i], z);
        end
    endtask

    task automatic op1(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] z);
        int n = 0;
        int acc;
        bus1.req0_a = a;
        bus1.req0_b = b;
        bus1.req0_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.req0_ready && n < 50);
        chk({tag, "_accept"}, 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus1.req0_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.rsp0_valid && n < 50);
        chk({tag, "_rsp_seen"}, 64'(n < 50), 64'd1);
        chk({tag, "_lat"}, 64'(cyc - acc), 64'd2);
        chk({tag, "_z"}, bus1.rsp_z, z);
        chk({tag, "_rsp1"}, 64'(bus1.rsp1_valid), 64'd0);
        $display("l1 response z=%h latency %0d", bus1.rsp_z, cyc - acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        bus0.req0_valid = 1'b0; bus0.req0_a = 32'd0; bus0.req0_b = 32'd0;
        bus0.req1_valid = 1'b0; bus0.req1_a = 32'd0; bus0.req1_b = 32'd0;
        bus1.req0_valid = 1'b0; bus1.req0_a = 32'd0; bus1.req0_b = 32'd0;
        bus1.req1_valid = 1'b0; bus1.req1_a = 32'd0; bus1.req1_b = 32'd0;

        // Reset state, with a request already pending
        bus0.req0_a = 32'hFFFF_FFFF;
        bus0.req0_b = 32'hFFFF_FFFF;
        bus0.req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus0.busy), 64'd0);
        chk("rst_mul_reset", 64'(bus0.mul_reset), 64'd1);
        chk("rst_mul_a", 64'(bus0.mul_a), 64'd0);
        chk("rst_mul_b", 64'(bus0.mul_b), 64'd0);
        chk("rst_rsp_z", bus0.rsp_z, 64'd0);
        chk("rst_ready0", 64'(bus0.req0_ready), 64'd0);
        chk("rst_rsp", 64'(bus0.rsp0_valid | bus0.rsp1_valid), 64'd0);
        chk("rst_busy_l1", 64'(bus1.busy), 64'd0);
        clr_q();
        reset = 1'b0;

        // Single op on port 0
        wait_accept(0);
        repeat (40) @(posedge clk);
        #1;
        chk("t1_nrsp", 64'(rsp_port_q.size()), 64'd1);
        chk_rsp("t1", 0, 0, 64'hFFFF_FFFE_0000_0001);
        if (rsp_cyc_q.size() > 0 && acc_cyc_q.size() > 0)
            chk("t1_lat", 64'(rsp_cyc_q[0] - acc_cyc_q[0]), 64'd33);

        // Simultaneous requests out of reset
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clr_q();
        bus0.req0_a = 32'hAAAA_AAAA; bus0.req0_b = 32'h8000_0000; bus0.req0_valid = 1'b1;
        bus0.req1_a = 32'd3;         bus0.req1_b = 32'd5;         bus0.req1_valid = 1'b1;
        wait_accept(0);
        wait_accept(1);
        repeat (40) @(posedge clk);
        #1;
        chk("t2_nacc", 64'(acc_port_q.size()), 64'd2);
        if (acc_cyc_q.size() == 2)
            chk("t2_next_accept", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd35);
        chk_rsp("t2a", 0, 0, 64'h5555_5555_0000_0000);
        chk_rsp("t2b", 1, 1, 64'h0000_0000_0000_000F);

        // Fairness with both ports permanently valid
        clr_q();
        bus0.req0_a = 32'd7;       bus0.req0_b = 32'd9;       bus0.req0_valid = 1'b1;
        bus0.req1_a = 32'h0001_0000; bus0.req1_b = 32'h0001_0000; bus0.req1_valid = 1'b1;
        n = 0;
        while (acc_port_q.size() < 4 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_naccept", 64'(acc_port_q.size()), 64'd4);
        bus0.req0_valid = 1'b0;
        bus0.req1_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t3_nrsp", 64'(rsp_port_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk_rsp($sformatf("t3_%0d", i), i, i % 2,
                    (i % 2 == 1) ? 64'h0000_0001_0000_0000 : 64'd63);
        for (int i = 1; i < 4; i++)
            if (rsp_cyc_q.size() > i)
                chk($sformatf("t3_space%0d", i), 64'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 64'd35);

        // Reset 10 cycles into a port 1 operation
        clr_q();
        bus0.req1_a = 32'd11; bus0.req1_b = 32'd13; bus0.req1_valid = 1'b1;
        wait_accept(1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t4_busy", 64'(bus0.busy), 64'd0);
        chk("t4_mul_reset", 64'(bus0.mul_reset), 64'd1);
        chk("t4_rsp_z", bus0.rsp_z, 64'd0);
        chk("t4_mul_a", 64'(bus0.mul_a), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("t4_no_rsp", 64'(rsp_port_q.size()), 64'd0);
        bus0.req0_a = 32'd6; bus0.req0_b = 32'd7; bus0.req0_valid = 1'b1;
        wait_accept(0);
        repeat (40) @(posedge clk);
        #1;
        chk("t4_nrsp", 64'(rsp_port_q.size()), 64'd1);
        chk_rsp("t4", 0, 0, 64'd42);

        // Port 0 withdraws while the arbiter is busy
        clr_q();
        bus0.req1_a = 32'd2; bus0.req1_b = 32'd3; bus0.req1_valid = 1'b1;
        wait_accept(1);
        repeat (5) @(posedge clk);
        #1;
        bus0.req0_a = 32'h1234_5678; bus0.req0_b = 32'd2; bus0.req0_valid = 1'b1;
        #1;
        chk("t5_busy", 64'(bus0.busy), 64'd1);
        chk("t5_ready0", 64'(bus0.req0_ready), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        bus0.req0_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t5_naccept", 64'(acc_port_q.size()), 64'd1);
        chk("t5_nrsp", 64'(rsp_port_q.size()), 64'd1);
        chk_rsp("t5", 0, 1, 64'd6);
        chk("t5_mul_a", 64'(bus0.mul_a), 64'd2);
        chk("t5_mul_b", 64'(bus0.mul_b), 64'd3);

        // Latency-1 instance
        op1("t6a", 32'd0, 32'hFFFF_FFFF, 64'd0);
        op1("t6b", 32'd3, 32'd4, 64'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
